instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the decode/execute controller.
//  - Owns the PC and issues 32-bit word reads to the unified memory.
//  - Buffers returned words in a small prefetch FIFO.
//  - Hands each word, with its PC, to the controller over a valid/ready handshake.
//  - Supports PC redirect (branch/jump) and stops fetching at the all-zero stop word.

---
 rtl/instr_fetch_unit_if.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundle of memory, redirect and instruction-delivery signals for the fetch stage.
// master = fetch unit side, slave = memory / controller side.
`timescale 1ns/1ps
interface instr_fetch_unit_if;
    logic [31:0] mem_read_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    modport master (
        output mem_read_address,
        output mem_funct3,
        input  mem_read_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready,
        output halted
    );

    modport slave (
        input  mem_read_address,
        input  mem_funct3,
        output mem_read_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers returned words
// in a prefetch FIFO and hands {word, pc} to the controller over valid/ready.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_unit_if.master     bus
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state_reg;
    logic            halted_reg;
    logic            pending_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     pc_inflight_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic [31:0]     data_mem_reg [FIFO_DEPTH];
    logic [31:0]     pc_mem_reg   [FIFO_DEPTH];

    logic [CW:0]     occupancy;
    logic            issue;
    logic            word_live;
    logic            push;
    logic            stop_word;
    logic            head_valid;
    logic            pop;
    logic [31:0]     redirect_target;

    // The in-flight word holds a reserved slot, so a push can never overflow.
    assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, pending_reg};
    assign issue      = (state_reg == RUN) && !bus.redirect_valid && (occupancy < DEPTH_C);

    // Words returning after a halt (issued in the stop-word cycle) are dropped.
    assign word_live  = pending_reg && (state_reg == RUN) && !bus.redirect_valid;
    assign push       = word_live && (bus.mem_read_data != 32'h0);
    assign stop_word  = word_live && (bus.mem_read_data == 32'h0);

    assign head_valid = (count_reg != '0);
    assign pop        = head_valid && bus.instr_ready;

    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            halted_reg      <= 1'b0;
            pending_reg     <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            pc_inflight_reg <= 32'h0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (bus.redirect_valid) begin
            state_reg       <= RUN;
            halted_reg      <= 1'b0;
            pending_reg     <= 1'b0;
            fetch_pc_reg    <= redirect_target;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            pending_reg <= issue;
            if (issue) begin
                pc_inflight_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + 32'd4;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                RUN: begin
                    if (stop_word) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_reg[wr_ptr_reg] <= bus.mem_read_data;
            pc_mem_reg[wr_ptr_reg]   <= pc_inflight_reg;
        end
    end

    assign bus.mem_read_address = fetch_pc_reg;
    assign bus.mem_funct3       = 3'b010;
    assign bus.halted           = halted_reg;
    assign bus.instr_valid      = head_valid;
    assign bus.instr_data       = head_valid ? data_mem_reg[rd_ptr_reg] : 32'h0;
    assign bus.instr_pc         = head_valid ? pc_mem_reg[rd_ptr_reg]   : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a 1-cycle memory model plus a
// scoreboard of expected {pc, word} deliveries checked at every handshake.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_ov [logic [31:0]];

    // Default memory contents are nonzero everywhere; overrides place specific words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (mem_ov.exists(a)) return mem_ov[a];
        w = a * 32'h9E37_79B1;
        return w | 32'h1;
    endfunction

    always @(posedge clk) bus.mem_read_data <= mem_word(bus.mem_read_address);

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_delivery: got pc=%h data=%h, required no delivery",
                         bus.instr_pc, bus.instr_data);
            end else begin
                e = sb.pop_front();
                if (bus.instr_pc !== e.pc || bus.instr_data !== e.data) begin
                    miscompares++;
                    $display("FAIL delivery: got pc=%h data=%h, required pc=%h data=%h",
                             bus.instr_pc, bus.instr_data, e.pc, e.data);
                end else begin
                    $display("deliver pc=%h data=%h", bus.instr_pc, bus.instr_data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic hold_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        sb.delete();
        mem_ov.delete();
        tick(2);
    endtask

    task automatic release_reset();
        reset = 1'b0;
    endtask

    task automatic redirect_pulse(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", bus.instr_valid); end
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b, required 0", bus.halted); end
        vectors++; if (bus.instr_data !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", bus.instr_data); end
        vectors++; if (bus.instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h, required 0", bus.instr_pc); end
        vectors++; if (bus.mem_funct3 !== 3'b010) begin miscompares++; $display("FAIL rst_funct3: got %b, required 010", bus.mem_funct3); end
        vectors++; if (bus.mem_read_address !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h, required 0", bus.mem_read_address); end
        release_reset();
        tick(1);
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got valid=%b, required 0", bus.instr_valid); end
        tick(1);
        vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL latency_2: got valid=%b, required 1", bus.instr_valid); end
        vectors++; if (bus.instr_pc !== 32'h0 || bus.instr_data !== mem_word(32'h0)) begin
            miscompares++; $display("FAIL first_head: got pc=%h data=%h, required pc=0 data=%h", bus.instr_pc, bus.instr_data, mem_word(32'h0)); end
    endtask

    task automatic test_stop_word();
        hold_reset();
        mem_ov[32'h0] = 32'h0010_0093;
        mem_ov[32'h4] = 32'h0020_0113;
        mem_ov[32'h8] = 32'h0;
        mem_ov[32'hC] = 32'hDEAD_BEEF;
        push_exp(32'h0);
        push_exp(32'h4);
        bus.instr_ready = 1'b1;
        release_reset();
        tick(12);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stop_drain: got %0d pending, required 0", sb.size()); end
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL stop_halted: got %b, required 1", bus.halted); end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL stop_valid: got %b, required 0", bus.instr_valid); end
        vectors++; if (bus.mem_read_address !== 32'h10) begin miscompares++; $display("FAIL stop_addr: got %h, required 00000010", bus.mem_read_address); end
    endtask

    task automatic test_stall();
        hold_reset();
        mem_ov[32'h20] = 32'h0;
        release_reset();
        tick(10);
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            miscompares++; $display("FAIL stall_head: got valid=%b pc=%h, required valid=1 pc=0", bus.instr_valid, bus.instr_pc); end
        vectors++; if (bus.mem_read_address !== 32'h10) begin miscompares++; $display("FAIL stall_addr: got %h, required 00000010", bus.mem_read_address); end
        for (int a = 0; a < 32'h20; a += 4) push_exp(32'(a));
        bus.instr_ready = 1'b1;
        tick(8);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stall_no_gaps: got %0d undelivered after 8 cycles, required 0", sb.size()); end
        tick(4);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL stall_halt: got %b, required 1", bus.halted); end
    endtask

    task automatic test_redirect_flush();
        hold_reset();
        mem_ov[32'h50] = 32'h0;
        release_reset();
        tick(4);
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            miscompares++; $display("FAIL flush_pre: got valid=%b pc=%h, required valid=1 pc=0", bus.instr_valid, bus.instr_pc); end
        redirect_pulse(32'h43);
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b, required 0", bus.instr_valid); end
        vectors++; if (bus.mem_read_address !== 32'h40) begin miscompares++; $display("FAIL flush_addr: got %h, required 00000040", bus.mem_read_address); end
        for (int a = 32'h40; a < 32'h50; a += 4) push_exp(32'(a));
        tick(1);
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL flush_r2: got valid=%b, required 0", bus.instr_valid); end
        tick(1);
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40) begin
            miscompares++; $display("FAIL flush_r3: got valid=%b pc=%h, required valid=1 pc=00000040", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL flush_drain: got %0d pending, required 0", sb.size()); end
        tick(3);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL flush_halt: got %b, required 1", bus.halted); end
    endtask

    task automatic test_halt_redirect();
        hold_reset();
        mem_ov[32'h8]   = 32'h0;
        mem_ov[32'h10C] = 32'h0;
        push_exp(32'h0);
        push_exp(32'h4);
        bus.instr_ready = 1'b1;
        release_reset();
        tick(10);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL hr_halted: got %b, required 1", bus.halted); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL hr_drain: got %0d pending, required 0", sb.size()); end
        redirect_pulse(32'h100);
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL hr_resume: got halted=%b, required 0", bus.halted); end
        vectors++; if (bus.mem_read_address !== 32'h100) begin miscompares++; $display("FAIL hr_addr: got %h, required 00000100", bus.mem_read_address); end
        push_exp(32'h100);
        push_exp(32'h104);
        push_exp(32'h108);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL hr_new_drain: got %0d pending, required 0", sb.size()); end
        tick(3);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL hr_rehalt: got %b, required 1", bus.halted); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        mem_ov[32'h10] = 32'h0;
        release_reset();
        tick(10);
        vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full: got valid=%b, required 1", bus.instr_valid); end
        reset = 1'b1;
        #1;
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b, required 0", bus.instr_valid); end
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL mid_halted: got %b, required 0", bus.halted); end
        vectors++; if (bus.instr_pc !== 32'h0) begin miscompares++; $display("FAIL mid_pc: got %h, required 0", bus.instr_pc); end
        tick(1);
        for (int a = 0; a < 32'h10; a += 4) push_exp(32'(a));
        bus.instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL mid_drain: got %0d pending, required 0", sb.size()); end
        tick(3);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL mid_halt: got %b, required 1", bus.halted); end
    endtask

    task automatic test_redirect_on_stop();
        hold_reset();
        mem_ov[32'h8]   = 32'h0;
        mem_ov[32'h208] = 32'h0;
        push_exp(32'h0);
        push_exp(32'h4);
        bus.instr_ready = 1'b1;
        release_reset();
        tick(3);
        redirect_pulse(32'h200);
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL ros_halted: got %b, required 0", bus.halted); end
        vectors++; if (bus.mem_read_address !== 32'h200) begin miscompares++; $display("FAIL ros_addr: got %h, required 00000200", bus.mem_read_address); end
        push_exp(32'h200);
        push_exp(32'h204);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL ros_drain: got %0d pending, required 0", sb.size()); end
        tick(3);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL ros_rehalt: got %b, required 1", bus.halted); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stop_word();
        test_stall();
        test_redirect_flush();
        test_halt_redirect();
        test_reset_mid();
        test_redirect_on_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
